// File: rtl/pcie_tlp_tx.sv
// Transmit-side TLP formatter: arbitrates CplD / MWr / MRd requests and
// drives the 64-bit AXI-stream TX port of the 7-series PCIe core.
module pcie_tlp_tx #(
    parameter bit FORCE_64BIT_ADDR = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pcie_id,

    input  logic        read_completion_valid,
    input  logic [23:0] read_completion_rid_tag,
    input  logic [3:0]  read_completion_lower_addr,
    input  logic [63:0] read_completion_data,
    output logic        read_completion_ready,

    input  logic        write_request_valid,
    input  logic [63:0] write_request_address,
    input  logic [63:0] write_request_data,
    output logic        write_request_ready,

    input  logic        read_request_valid,
    input  logic [63:0] read_request_address,
    input  logic [7:0]  read_request_tag,
    output logic        read_request_ready,

    input  logic        axis_tx_tready,
    output logic [63:0] axis_tx_tdata,
    output logic        axis_tx_1dw,
    output logic        axis_tx_tlast,
    output logic        axis_tx_tvalid
);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, DONE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_CPL, SRC_WR, SRC_RD} src_t;

    state_t state, state_next;
    src_t   src, src_next, win, sel;

    logic [63:0] beat0, beat1, beat2;
    logic        two_beats, end_1dw;

    logic [63:0] tdata_next;
    logic        tvalid_next, tlast_next, one_dw_next;
    logic        xfer;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Header and payload DWs for each source
    logic [31:0] cpl_dw1, cpl_dw2, cpl_d0, cpl_d1;
    logic [31:0] wr_dw1, wr_hi, wr_lo, wr_d0, wr_d1;
    logic [31:0] rd_dw1, rd_hi, rd_lo;
    logic        wr_64, rd_64;

    assign cpl_dw1 = {pcie_id, 3'b000, 1'b0, 12'd8};
    assign cpl_dw2 = {read_completion_rid_tag, 1'b0,
                      read_completion_lower_addr, 3'b000};
    assign cpl_d0  = bswap(read_completion_data[31:0]);
    assign cpl_d1  = bswap(read_completion_data[63:32]);

    assign wr_dw1 = {pcie_id, 8'h00, 8'hFF};
    assign wr_hi  = write_request_address[63:32];
    assign wr_lo  = write_request_address[31:0] & 32'hFFFF_FFFC;
    assign wr_d0  = bswap(write_request_data[31:0]);
    assign wr_d1  = bswap(write_request_data[63:32]);
    assign wr_64  = FORCE_64BIT_ADDR || (wr_hi != 32'h0);

    assign rd_dw1 = {pcie_id, read_request_tag, 8'hFF};
    assign rd_hi  = read_request_address[63:32];
    assign rd_lo  = read_request_address[31:0] & 32'hFFFF_FFFC;
    assign rd_64  = FORCE_64BIT_ADDR || (rd_hi != 32'h0);

    always_comb begin
        win = SRC_NONE;
        if (read_completion_valid)
            win = SRC_CPL;
        else if (write_request_valid)
            win = SRC_WR;
        else if (read_request_valid)
            win = SRC_RD;
    end

    assign sel = (state == IDLE) ? win : src;

    // Beat packing for the selected source
    always_comb begin
        beat0     = 64'h0;
        beat1     = 64'h0;
        beat2     = 64'h0;
        two_beats = 1'b0;
        end_1dw   = 1'b0;
        case (sel)
            SRC_CPL: begin
                beat0   = {cpl_dw1, 32'h4A00_0002};
                beat1   = {cpl_d0, cpl_dw2};
                beat2   = {32'h0, cpl_d1};
                end_1dw = 1'b1;
            end
            SRC_WR: begin
                if (wr_64) begin
                    beat0 = {wr_dw1, 32'h6000_0002};
                    beat1 = {wr_lo, wr_hi};
                    beat2 = {wr_d1, wr_d0};
                end else begin
                    beat0   = {wr_dw1, 32'h4000_0002};
                    beat1   = {wr_d0, wr_lo};
                    beat2   = {32'h0, wr_d1};
                    end_1dw = 1'b1;
                end
            end
            SRC_RD: begin
                two_beats = 1'b1;
                if (rd_64) begin
                    beat0 = {rd_dw1, 32'h2000_0002};
                    beat1 = {rd_lo, rd_hi};
                end else begin
                    beat0   = {rd_dw1, 32'h0000_0002};
                    beat1   = {32'h0, rd_lo};
                    end_1dw = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign xfer = axis_tx_tvalid && axis_tx_tready;

    always_comb begin
        state_next  = state;
        src_next    = src;
        tdata_next  = axis_tx_tdata;
        tvalid_next = axis_tx_tvalid;
        tlast_next  = axis_tx_tlast;
        one_dw_next = axis_tx_1dw;
        unique case (state)
            IDLE: begin
                if (win != SRC_NONE) begin
                    src_next    = win;
                    tdata_next  = beat0;
                    tvalid_next = 1'b1;
                    tlast_next  = 1'b0;
                    one_dw_next = 1'b0;
                    state_next  = B0;
                end
            end
            B0: begin
                if (xfer) begin
                    tdata_next  = beat1;
                    tlast_next  = two_beats;
                    one_dw_next = two_beats && end_1dw;
                    state_next  = B1;
                end
            end
            B1: begin
                if (xfer) begin
                    if (axis_tx_tlast) begin
                        tdata_next  = 64'h0;
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        one_dw_next = 1'b0;
                        state_next  = DONE;
                    end else begin
                        tdata_next  = beat2;
                        tlast_next  = 1'b1;
                        one_dw_next = end_1dw;
                        state_next  = B2;
                    end
                end
            end
            B2: begin
                if (xfer) begin
                    tdata_next  = 64'h0;
                    tvalid_next = 1'b0;
                    tlast_next  = 1'b0;
                    one_dw_next = 1'b0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                src_next   = SRC_NONE;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            src            <= SRC_NONE;
            axis_tx_tdata  <= 64'h0;
            axis_tx_tvalid <= 1'b0;
            axis_tx_tlast  <= 1'b0;
            axis_tx_1dw    <= 1'b0;
        end else begin
            state          <= state_next;
            src            <= src_next;
            axis_tx_tdata  <= tdata_next;
            axis_tx_tvalid <= tvalid_next;
            axis_tx_tlast  <= tlast_next;
            axis_tx_1dw    <= one_dw_next;
        end
    end

    assign read_completion_ready = (state == DONE) && (src == SRC_CPL);
    assign write_request_ready   = (state == DONE) && (src == SRC_WR);
    assign read_request_ready    = (state == DONE) && (src == SRC_RD);

endmodule

// File: tb/tb_pcie_tlp_tx.sv
// Bench for pcie_tlp_tx: a DW-stream model packs expected beats into a
// scoreboard that is compared with the TX port every cycle.
module tb_pcie_tlp_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pcie_id = 16'h0100;

    logic [23:0] cpl_rt = '0;
    logic [3:0]  cpl_la = '0;
    logic [63:0] cpl_data = '0;
    logic [63:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [7:0]  rd_tag = '0;
    logic        tready = 1'b1;

    logic        cpl_valid, wr_valid, rd_valid;
    logic        cpl_ready, wr_ready, rd_ready;
    logic [63:0] tdata;
    logic        one_dw, tlast, tvalid;

    int issue_cnt [3] = '{0, 0, 0};
    int done_cnt  [3] = '{0, 0, 0};

    assign cpl_valid = issue_cnt[0] != done_cnt[0];
    assign wr_valid  = issue_cnt[1] != done_cnt[1];
    assign rd_valid  = issue_cnt[2] != done_cnt[2];

    always #5 clock = ~clock;

    pcie_tlp_tx #(.FORCE_64BIT_ADDR(1'b0)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .pcie_id                    (pcie_id),
        .read_completion_valid      (cpl_valid),
        .read_completion_rid_tag    (cpl_rt),
        .read_completion_lower_addr (cpl_la),
        .read_completion_data       (cpl_data),
        .read_completion_ready      (cpl_ready),
        .write_request_valid        (wr_valid),
        .write_request_address      (wr_addr),
        .write_request_data         (wr_data),
        .write_request_ready        (wr_ready),
        .read_request_valid         (rd_valid),
        .read_request_address       (rd_addr),
        .read_request_tag           (rd_tag),
        .read_request_ready         (rd_ready),
        .axis_tx_tready             (tready),
        .axis_tx_tdata              (tdata),
        .axis_tx_1dw                (one_dw),
        .axis_tx_tlast              (tlast),
        .axis_tx_tvalid             (tvalid)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        one_dw;
        int          id;
        int          idx;
    } beat_t;

    typedef struct {
        int src;
        int id;
    } rdy_t;

    beat_t exp_q[$];
    rdy_t  exp_rdy[$];

    int checks = 0;
    int errors = 0;
    int next_id = 0;
    int xfer_cnt = 0;
    int cyc = 0;
    int last_tlast_cyc = -100;
    int gap_min = -1;
    int gap_max = -1;
    bit rand_ready = 1'b0;
    bit rst_at_edge = 1'b0;

    task automatic check(input string name, input logic [71:0] got,
                         input logic [71:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Build the TLP as a DW stream, then pack pairs of DWs into beats
    task automatic push_tlp(input int kind);
        logic [31:0] dw[$];
        logic [63:0] a;
        logic        is64;
        beat_t       b;
        rdy_t        r;
        int          n;
        int          nb;
        a    = (kind == 1) ? wr_addr : rd_addr;
        is64 = (a[63:32] != 32'h0);
        if (kind == 0) begin
            dw.push_back(32'h4A00_0002);
            dw.push_back({pcie_id, 16'h0008});
            dw.push_back({cpl_rt, 1'b0, cpl_la, 3'b000});
            dw.push_back(bswap(cpl_data[31:0]));
            dw.push_back(bswap(cpl_data[63:32]));
        end else begin
            if (kind == 1) begin
                dw.push_back(is64 ? 32'h6000_0002 : 32'h4000_0002);
                dw.push_back({pcie_id, 16'h00FF});
            end else begin
                dw.push_back(is64 ? 32'h2000_0002 : 32'h0000_0002);
                dw.push_back({pcie_id, rd_tag, 8'hFF});
            end
            if (is64)
                dw.push_back(a[63:32]);
            dw.push_back({a[31:2], 2'b00});
            if (kind == 1) begin
                dw.push_back(bswap(wr_data[31:0]));
                dw.push_back(bswap(wr_data[63:32]));
            end
        end
        n  = dw.size();
        nb = (n + 1) / 2;
        for (int i = 0; i < nb; i++) begin
            b.data   = {(2 * i + 1 < n) ? dw[2 * i + 1] : 32'h0, dw[2 * i]};
            b.last   = (i == nb - 1);
            b.one_dw = (i == nb - 1) && (n % 2 == 1);
            b.id     = next_id;
            b.idx    = i;
            exp_q.push_back(b);
        end
        r.src = kind;
        r.id  = next_id;
        exp_rdy.push_back(r);
        next_id++;
    endtask

    task automatic issue(input int kind);
        push_tlp(kind);
        issue_cnt[kind]++;
    endtask

    task automatic pin(input int base, input int idx, input logic [63:0] d,
                       input logic l, input logic o);
        check($sformatf("model_pin_t%0d_b%0d", exp_q[base + idx].id, idx),
              {6'h0, exp_q[base + idx].last, exp_q[base + idx].one_dw,
               exp_q[base + idx].data},
              {6'h0, l, o, d});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_rdy.size() != 0) && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("drain", 72'(exp_q.size() + exp_rdy.size()), 72'd0);
    endtask

    always @(posedge clock) begin
        rst_at_edge = reset;
        #1;
        tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: bus beats, stalls and ready pulses
    logic        stall_prev = 1'b0;
    logic        cont_prev = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        prev_1dw = 1'b0;

    always @(negedge clock) begin
        beat_t      e;
        rdy_t       r;
        logic [2:0] rdy_bits;
        int         pend;
        cyc++;
        rdy_bits = {rd_ready, wr_ready, cpl_ready};
        if (rst_at_edge) begin
            check("reset_outputs", {rdy_bits, tvalid, tlast, one_dw, tdata},
                  72'd0);
            stall_prev = 1'b0;
            cont_prev  = 1'b0;
        end else if (reset) begin
            stall_prev = 1'b0;
            cont_prev  = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {5'h0, tvalid, tlast, one_dw, tdata},
                      {5'h0, 1'b1, prev_last, prev_1dw, prev_data});
            if (cont_prev)
                check("no_bubble", 72'(tvalid), 72'd1);
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {6'h0, tlast, one_dw, tdata}, 72'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat_t%0d_b%0d", e.id, e.idx),
                          {6'h0, tlast, one_dw, tdata},
                          {6'h0, e.last, e.one_dw, e.data});
                    if (e.idx == 0 && e.id > gap_min && e.id <= gap_max)
                        check("idle_gap", 72'(cyc - last_tlast_cyc), 72'd3);
                end
                if (tlast)
                    last_tlast_cyc = cyc;
                xfer_cnt++;
            end
            if (rdy_bits != 3'b000) begin
                if (exp_rdy.size() == 0) begin
                    check("extra_ready", 72'(rdy_bits), 72'd0);
                end else begin
                    r = exp_rdy.pop_front();
                    check($sformatf("ready_t%0d", r.id), 72'(rdy_bits),
                          72'(3'b001 << r.src));
                    pend = 0;
                    foreach (exp_q[i])
                        if (exp_q[i].id == r.id)
                            pend++;
                    check($sformatf("ready_after_last_t%0d", r.id),
                          72'(pend), 72'd0);
                    done_cnt[r.src]++;
                end
            end
            stall_prev = tvalid && !tready;
            cont_prev  = tvalid && tready && !tlast;
            prev_data  = tdata;
            prev_last  = tlast;
            prev_1dw   = one_dw;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int x0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // CplD vector
        @(posedge clock); #1;
        cpl_rt   = 24'h012345;
        cpl_la   = 4'h3;
        cpl_data = 64'h1122_3344_5566_7788;
        base = exp_q.size();
        issue(0);
        pin(base, 0, 64'h01000008_4A000002, 1'b0, 1'b0);
        pin(base, 1, 64'h88776655_01234518, 1'b0, 1'b0);
        pin(base, 2, 64'h00000000_44332211, 1'b1, 1'b1);
        drain(40);

        // MWr with 64-bit address
        @(posedge clock); #1;
        wr_addr = 64'h0000_0001_0000_0100;
        wr_data = 64'h0000_0000_0000_0005;
        base = exp_q.size();
        issue(1);
        pin(base, 0, 64'h010000FF_60000002, 1'b0, 1'b0);
        pin(base, 1, 64'h00000100_00000001, 1'b0, 1'b0);
        pin(base, 2, 64'h00000000_05000000, 1'b1, 1'b0);
        drain(40);

        // MRd with 32-bit address
        @(posedge clock); #1;
        rd_addr = 64'h0000_0000_0000_1000;
        rd_tag  = 8'h07;
        base = exp_q.size();
        issue(2);
        pin(base, 0, 64'h010007FF_00000002, 1'b0, 1'b0);
        pin(base, 1, 64'h00000000_00001000, 1'b1, 1'b1);
        drain(40);

        // MWr 3DW and MRd 4DW, low address bits dropped, other id
        @(posedge clock); #1;
        pcie_id = 16'hABCD;
        wr_addr = 64'h0000_0000_2000_0007;
        wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        issue(1);
        drain(40);
        @(posedge clock); #1;
        rd_addr = 64'h0000_00FF_1234_567B;
        rd_tag  = 8'hA5;
        issue(2);
        drain(40);

        // All three together: priority order and idle gap
        @(posedge clock); #1;
        pcie_id  = 16'h0100;
        cpl_rt   = 24'hBEEF42;
        cpl_la   = 4'hF;
        cpl_data = 64'h0123_4567_89AB_CDEF;
        wr_addr  = 64'h0000_0000_8000_0010;
        wr_data  = 64'hFFEE_DDCC_BBAA_9988;
        rd_addr  = 64'h0000_0001_0000_0000;
        rd_tag   = 8'h3C;
        gap_min  = next_id;
        gap_max  = next_id + 2;
        issue(0);
        issue(1);
        issue(2);
        drain(60);
        gap_min = -1;
        gap_max = -1;

        // MWr64 under random back-pressure
        @(posedge clock); #1;
        rand_ready = 1'b1;
        wr_addr = 64'h0000_0001_0000_0100;
        wr_data = 64'h0000_0000_0000_0005;
        x0 = xfer_cnt;
        issue(1);
        drain(300);
        rand_ready = 1'b0;
        check("mwr_xfer_count", 72'(xfer_cnt - x0), 72'd3);

        // Reset while the CplD is in its second beat
        @(posedge clock); #1;
        cpl_rt   = 24'h012345;
        cpl_la   = 4'h3;
        cpl_data = 64'h1122_3344_5566_7788;
        issue(0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        exp_rdy.delete();
        push_tlp(0);
        @(posedge clock);
        @(negedge clock);
        check("reset_mid_tvalid", 72'(tvalid), 72'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        drain(40);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
